// File: rtl/hex_display_rx_if.sv
// Bundle between a 4-digit multiplexed 7-segment driver and the receiver that
// decodes it back into a 16-bit word.
interface hex_display_rx_if;
    logic [3:0]  i_anodes;
    logic [7:0]  i_segments;
    logic [15:0] o_data;
    logic        o_valid;
    logic        o_err;
    logic [3:0]  o_mask;

    modport master (
        output i_anodes, i_segments,
        input  o_data, o_valid, o_err, o_mask
    );

    modport slave (
        input  i_anodes, i_segments,
        output o_data, o_valid, o_err, o_mask
    );
endinterface

// File: rtl/hex_display_rx.sv
// Receiver for a multiplexed 4-digit 7-segment bus: waits for each digit to
// settle, decodes it to a nibble and publishes the word once all four are seen.

// One digit slot: shadow nibble plus its "captured this frame" flag.
module hex_display_rx_digit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_i,
    input  logic       clr_i,
    input  logic [3:0] nib_i,
    output logic [3:0] nxt_o,
    output logic       cap_o
);
    logic [3:0] nib_q;
    logic       cap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nib_q <= 4'h0;
            cap_q <= 1'b0;
        end else begin
            if (wr_i) nib_q <= nib_i;
            if (clr_i)     cap_q <= 1'b0;
            else if (wr_i) cap_q <= 1'b1;
        end
    end

    // Shadow value including a write happening this cycle, so the frame that
    // completes on this write publishes the fresh nibble.
    assign nxt_o = wr_i ? nib_i : nib_q;
    assign cap_o = cap_q;
endmodule

module hex_display_rx #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input logic             clk,
    input logic             rst_n,
    hex_display_rx_if.slave bus
);
    localparam logic [7:0] CNT_MAX = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_e;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
        logic [3:0] nib;
    } sample_t;

    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        r = 5'h00;
        case (s)
            7'b1111110: r = {1'b1, 4'h0};
            7'b0110000: r = {1'b1, 4'h1};
            7'b1101101: r = {1'b1, 4'h2};
            7'b1111001: r = {1'b1, 4'h3};
            7'b0110011: r = {1'b1, 4'h4};
            7'b1011011: r = {1'b1, 4'h5};
            7'b1011111: r = {1'b1, 4'h6};
            7'b1110000: r = {1'b1, 4'h7};
            7'b1111111: r = {1'b1, 4'h8};
            7'b1111011: r = {1'b1, 4'h9};
            7'b1110111: r = {1'b1, 4'hA};
            7'b0011111: r = {1'b1, 4'hB};
            7'b1001110: r = {1'b1, 4'hC};
            7'b0111101: r = {1'b1, 4'hD};
            7'b1001111: r = {1'b1, 4'hE};
            7'b1000111: r = {1'b1, 4'hF};
            default:    r = 5'h00;
        endcase
        return r;
    endfunction

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  an_q;
    logic [7:0]  seg_q;
    logic [15:0] data_q, data_d;
    logic        valid_q, err_q;

    logic        blank, an_chg, stable, do_sample;
    logic        wr, full;
    logic [4:0]  dec;
    sample_t     smp;
    logic [3:0]  cap;
    logic [3:0][3:0] nib_nxt;

    assign blank  = (bus.i_anodes == 4'b1111);
    assign an_chg = (bus.i_anodes != an_q);
    assign stable = !an_chg && (bus.i_segments == seg_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'h00;
            an_q    <= 4'h0;
            seg_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            an_q    <= bus.i_anodes;
            seg_q   <= bus.i_segments;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        do_sample = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = 8'h00;
                if (!blank) state_d = SETTLE;
            end
            SETTLE: begin
                if (blank) begin
                    state_d = IDLE;
                    cnt_d   = 8'h00;
                end else if (!stable) begin
                    cnt_d = 8'h00;
                end else if (cnt_q == CNT_MAX) begin
                    do_sample = 1'b1;
                    state_d   = HOLD;
                    cnt_d     = 8'h00;
                end else begin
                    cnt_d = cnt_q + 8'h01;
                end
            end
            HOLD: begin
                // Only an anode change ends the hold; segment wiggles are ignored.
                if (an_chg) begin
                    state_d = blank ? IDLE : SETTLE;
                    cnt_d   = 8'h00;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'h00;
            end
        endcase
    end

    always_comb begin
        smp     = '0;
        dec     = seg_decode(bus.i_segments[7:1]);
        smp.nib = dec[3:0];
        case (bus.i_anodes)
            4'b1110: begin smp.idx = 2'd0; smp.hit = dec[4]; end
            4'b1101: begin smp.idx = 2'd1; smp.hit = dec[4]; end
            4'b1011: begin smp.idx = 2'd2; smp.hit = dec[4]; end
            4'b0111: begin smp.idx = 2'd3; smp.hit = dec[4]; end
            default: smp.hit = 1'b0;
        endcase
    end

    assign wr   = do_sample && smp.hit;
    assign full = wr && ((cap | (4'b0001 << smp.idx)) == 4'b1111);

    for (genvar k = 0; k < 4; k++) begin : g_dig
        hex_display_rx_digit u_dig (
            .clk   (clk),
            .rst_n (rst_n),
            .wr_i  (wr && (smp.idx == 2'(k))),
            .clr_i (full),
            .nib_i (smp.nib),
            .nxt_o (nib_nxt[k]),
            .cap_o (cap[k])
        );
    end

    assign data_d = full ? nib_nxt : data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= 16'h0000;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= full;
            err_q   <= do_sample && !smp.hit;
        end
    end

    assign bus.o_data  = data_q;
    assign bus.o_valid = valid_q;
    assign bus.o_err   = err_q;
    assign bus.o_mask  = cap;
endmodule

// File: tb/tb_hex_display_rx.sv
// Directed bench for hex_display_rx: run-length reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_hex_display_rx;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    hex_display_rx_if bus();

    hex_display_rx #(.SETTLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [6:0] lut [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                             7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    // Reference model: a value is sampled once it has been on the bus for
    // S+1 consecutive edges, at most once per anode activation.
    logic [11:0] m_last;
    logic [3:0]  m_last_an;
    int          m_run;
    bit          m_done;
    logic [3:0]  m_sh [4];
    logic [3:0]  m_mask;
    logic [15:0] m_data;
    logic        m_valid, m_err;
    int          m_nz, m_k;
    bit          m_hit;
    logic [3:0]  m_nib;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last = 12'h000; m_last_an = 4'h0; m_run = 0; m_done = 0;
            for (int i = 0; i < 4; i++) m_sh[i] = 4'h0;
            m_mask = 4'h0; m_data = 16'h0; m_valid = 0; m_err = 0;
        end else begin
            m_valid = 0; m_err = 0;
            if ({bus.i_anodes, bus.i_segments} == m_last) m_run++;
            else m_run = 1;
            if (bus.i_anodes != m_last_an) m_done = 0;
            m_last = {bus.i_anodes, bus.i_segments};
            m_last_an = bus.i_anodes;
            if (m_run >= S + 1 && !m_done && bus.i_anodes != 4'hF) begin
                m_done = 1;
                m_nz = 0; m_k = 0; m_hit = 0; m_nib = 4'h0;
                for (int i = 0; i < 4; i++)
                    if (!bus.i_anodes[i]) begin m_nz++; m_k = i; end
                for (int v = 0; v < 16; v++)
                    if (lut[v] == bus.i_segments[7:1]) begin m_hit = 1; m_nib = 4'(v); end
                if (m_nz == 1 && m_hit) begin
                    m_sh[m_k] = m_nib;
                    m_mask[m_k] = 1'b1;
                    if (m_mask == 4'hF) begin
                        m_data = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
                        m_valid = 1;
                        m_mask = 4'h0;
                    end
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    int          vcnt = 0, ecnt = 0;
    logic [15:0] vdata = 16'h0;

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ({bus.o_data, bus.o_valid, bus.o_err, bus.o_mask} !==
                {m_data, m_valid, m_err, m_mask}) begin
                failures++;
                $display("FAIL cycle_model t=%0t data=%h/%h valid=%b/%b err=%b/%b mask=%b/%b (dut/model)",
                         $time, bus.o_data, m_data, bus.o_valid, m_valid,
                         bus.o_err, m_err, bus.o_mask, m_mask);
            end
            if (bus.o_valid === 1'b1) begin vcnt++; vdata = bus.o_data; end
            if (bus.o_err === 1'b1) ecnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input logic [3:0] nib, input logic dp);
        return {lut[nib], dp};
    endfunction

    task automatic drive(input logic [3:0] an, input logic [7:0] seg, input int n);
        bus.i_anodes = an;
        bus.i_segments = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [15:0] w, input int cyc, input logic dp);
        logic [3:0] an;
        for (int k = 0; k < 4; k++) begin
            an = 4'hF;
            an[k] = 1'b0;
            drive(an, pat(w[4*k +: 4], dp), cyc);
        end
    endtask

    int v0, e0;
    logic [7:0] gp;

    initial begin
        bus.i_anodes = 4'hF;
        bus.i_segments = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.o_data, bus.o_valid, bus.o_err, bus.o_mask, 10'h0}, 32'h0);
        rst_n = 1'b1;
        drive(4'hF, 8'h00, 2);

        // Driver-style scan
        v0 = vcnt;
        scan(16'h1A2F, 8, 1'b0);
        chk("scan1_valid_count", vcnt - v0, 1);
        chk("scan1_data", vdata, 16'h1A2F);
        chk("scan1_mask", bus.o_mask, 4'b0000);
        drive(4'hF, 8'h00, 2);

        // Settle boundary: S edges is one short, S+1 samples
        drive(4'b1110, 8'b11110010, S);
        drive(4'hF, 8'h00, 2);
        chk("settle_short_mask", bus.o_mask, 4'b0000);
        drive(4'b1110, 8'b11110010, S + 1);
        chk("settle_exact_mask", bus.o_mask, 4'b0001);
        v0 = vcnt;
        drive(4'b1101, pat(4'h4, 1'b0), S + 3);
        drive(4'b1011, pat(4'h5, 1'b0), S + 3);
        drive(4'b0111, pat(4'h6, 1'b0), S + 3);
        chk("settle_frame_valid", vcnt - v0, 1);
        chk("settle_frame_data", vdata, 16'h6543);

        // Errors: two anodes low, then blank pattern on digit 2
        e0 = ecnt;
        drive(4'b1100, pat(4'h7, 1'b0), 8);
        chk("err_twohot_count", ecnt - e0, 1);
        chk("err_twohot_mask", bus.o_mask, 4'b0000);
        drive(4'b1011, 8'b00000001, 8);
        chk("err_badseg_count", ecnt - e0, 2);
        chk("err_badseg_mask", bus.o_mask, 4'b0000);

        // Segment glitch every third cycle blocks sampling
        gp = pat(4'h9, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(4'b1101, gp, 2);
            drive(4'b1101, gp ^ 8'h80, 1);
        end
        chk("glitch_nosample_mask", bus.o_mask, 4'b0000);
        drive(4'b1101, gp, S + 1);
        chk("glitch_then_sample_mask", bus.o_mask, 4'b0010);
        drive(4'hF, 8'h00, 2);

        // BEEF twice with dp lit
        v0 = vcnt;
        scan(16'hBEEF, 8, 1'b1);
        chk("beef1_valid_count", vcnt - v0, 1);
        chk("beef1_data", vdata, 16'hBEEF);
        scan(16'hBEEF, 8, 1'b1);
        chk("beef2_valid_count", vcnt - v0, 2);
        chk("beef2_data", vdata, 16'hBEEF);
        chk("beef2_mask", bus.o_mask, 4'b0000);
        drive(4'hF, 8'h00, 2);

        // Mid-frame asynchronous reset
        drive(4'b1110, pat(4'h1, 1'b0), S + 3);
        drive(4'b1101, pat(4'h2, 1'b0), S + 3);
        chk("midframe_mask", bus.o_mask, 4'b0011);
        #2 rst_n = 1'b0;
        bus.i_anodes = 4'hF;
        #1;
        chk("async_rst_mask", bus.o_mask, 4'b0000);
        chk("async_rst_data", bus.o_data, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'hF, 8'h00, 2);
        v0 = vcnt;
        scan(16'h1234, 8, 1'b0);
        drive(4'hF, 8'h00, 4);
        chk("post_rst_valid_count", vcnt - v0, 1);
        chk("post_rst_data", vdata, 16'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hex_display_rx.md
Name: hex_display_rx

Overview:
- Receiving end of the 4-digit multiplexed 7-segment interface: watches the active-low one-hot anode strobes and segment bus driven by the display driver, and decodes each digit back into a nibble.
- Once all four digit positions have been captured, publishes the reassembled 16-bit word with a one-cycle valid strobe.
- Used as an in-fabric loopback checker for display paths and as a bench monitor for boards.

Parameters:
- SETTLE_CYCLES, 4, consecutive cycles anodes+segments must be unchanged before a digit is sampled; legal range 1..255.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- i_anodes  input  4  digit enables, active low; bit k low selects digit k, digit 0 = i_data[3:0]
- i_segments  input  8  segments, bit7=a, bit6=b … bit1=g, bit0=dp; 1 = lit
- o_data  output  16  last complete decoded word; digit k in [4k+3:4k]
- o_valid  output  1  one-cycle pulse when o_data updates
- o_err  output  1  one-cycle pulse on a settled but undecodable sample
- o_mask  output  4  digits captured in the current frame

Behaviour:
- Reset (async assert, sync release): o_data=16'h0000, o_valid=0, o_err=0, o_mask=4'b0000, settle counter=0, state IDLE, all input history registers cleared.
- Inputs registered once (prev_an, prev_seg). Per-cycle "stable" = current inputs equal the previous-cycle registered copy.
- Decode table, seg[7:1] with dp ignored:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
  - any other pattern = invalid.
- States:
  - IDLE: i_anodes==4'b1111 (blank); counter held 0. Any other value -> SETTLE with counter=0.
  - SETTLE: counter increments while stable; any change resets counter to 0 and stays in SETTLE, or goes to IDLE if the anodes become 4'b1111. On the cycle counter reaches SETTLE_CYCLES-1 while stable -> perform sample, go to HOLD.
  - HOLD: one sample per anode activation; ignore inputs until i_anodes changes -> SETTLE (counter=0), or -> IDLE if 4'b1111. A segment-only change in HOLD does not resample.
- Sample action:
  - Anodes exactly one-hot-low (1110/1101/1011/0111) and pattern valid: write nibble into shadow digit k and set o_mask[k].
  - Otherwise: pulse o_err the next cycle; shadow and mask unchanged.
  - Rewriting an already-captured digit overwrites it; the mask bit stays set.
- Frame completion:
  - On the cycle o_mask becomes 4'b1111: o_data <= shadow (including this sample), o_valid=1 for exactly one cycle, o_mask <= 4'b0000 the same cycle, so o_mask never reads 1111.
  - o_valid pulses even if the value is unchanged.
- Latency: from the first cycle of a new stable anode/segment value to the mask/shadow update is SETTLE_CYCLES+1 clocks (1 input register + SETTLE_CYCLES-1 counting + 1 write); o_valid/o_err follow the same timing.
- Counter width = 8 bits; never wraps, because it saturates via the state change to HOLD.
- Simultaneous anode and segment change counts as one change (counter restarts once).
- Reset mid-frame discards partial shadow/mask; o_data returns to 0.

Test Plan:
- Reset, then drive a driver-style scan of 16'h1A2F with ≥8 cycles per digit -> within one full scan, o_valid pulses once, o_data=16'h1A2F, o_mask returns to 0000.
- Hold i_anodes=1110 with i_segments=8'b11110010 for exactly SETTLE_CYCLES-1 stable cycles then change -> no sample, o_mask=0000; hold SETTLE_CYCLES cycles -> o_mask=0001, shadow digit0=3.
- i_anodes=1100 (two digits) with a valid pattern, stable -> o_err pulses once, o_mask unchanged; i_segments=8'b00000001 on digit 2 -> o_err pulse.
- Segment glitch: toggle i_segments for one cycle every 3 cycles with SETTLE_CYCLES=4 -> never samples; glitch stops -> samples after 4 stable cycles.
- Scan 16'hBEEF twice back-to-back -> two o_valid pulses, both with o_data=16'hBEEF; the dp bit set on every digit does not change the result.
- Assert rst_n low after digits 0 and 1 are captured -> o_mask=0000 and o_data=0 immediately (asynchronously); a full scan after release yields exactly one o_valid.
